stage_skid_buf: RTL and testbench

STAGE_SKID_BUF -- requirements
Module: stage_skid_buf

---
 rtl/stage_skid_buf.sv | 156 +++++++++++++++
 tb/tb_stage_skid_buf.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_skid_buf.sv
// -----------------------------------------------------------------------------
// stage_skid_buf
//
// Two-entry elastic buffer between two pipeline stages. A main register holds
// the oldest entry and is always what the downstream stage sees. A skid
// register catches one extra entry when the downstream stage stalls. Because of
// the skid register, in_ready depends only on local state, never on out_ready.
// This breaks the ready path between stages.
//
// Parameters
//   PAYLOAD_W   : payload width in bits
//   STALL_W     : width of the pipeline stall vector
//   STALL_IDX   : stall bit that freezes this stage
//   NOP_PAYLOAD : payload shown when nothing is held; also the reset value
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset; beats flush and stall
//   stall       : pipeline stall vector; stall[STALL_IDX] freezes this stage
//   flush       : discard all held entries at the next edge; beats stall
//   in_valid    : upstream offers in_payload
//   in_ready    : stage can accept an entry this cycle
//   in_payload  : upstream payload, passed through bit-exact
//   out_valid   : out_payload holds a valid entry
//   out_ready   : downstream consumes the entry this cycle
//   out_payload : oldest held entry, or NOP_PAYLOAD when empty
//   occupancy   : number of held entries, 0..2
// -----------------------------------------------------------------------------
module stage_skid_buf #(
  parameter int unsigned          PAYLOAD_W   = 110,
  parameter int unsigned          STALL_W     = 6,
  parameter int unsigned          STALL_IDX   = 3,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy
);

  // The state encoding is the entry count, so occupancy is the state itself.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q,  main_d;
  logic [PAYLOAD_W-1:0] skid_q,  skid_d;

  logic frz;
  logic push;
  logic pop;

  // Only one stall bit matters here. The whole vector is reduced into a sink
  // so the other bits are visibly consumed.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign frz = stall[STALL_IDX];

  // Handshake qualifiers. Freeze and flush both remove the handshake. Because
  // of this, push and pop cannot fire while the stage is frozen or flushing.
  assign in_ready  = (state_q != ST_FULL)  & ~frz & ~flush;
  assign out_valid = (state_q != ST_EMPTY) & ~frz & ~flush;

  assign push = in_valid  & in_ready;
  assign pop  = out_valid & out_ready;

  // Downstream always reads the main register. The skid register is never
  // exposed directly.
  assign out_payload = (state_q != ST_EMPTY) ? main_q : NOP_PAYLOAD;
  assign occupancy   = state_q;

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a hold value first. A path that
    // leaves one unassigned would otherwise infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Contents are left as they are. They cannot be seen once the state is
      // EMPTY, and they are overwritten by the next push.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = in_payload;
            state_d = ST_ONE;
          end
        end

        ST_ONE: begin
          if (push && pop) begin
            // Streaming case: the new entry replaces the one leaving.
            main_d = in_payload;
          end else if (push) begin
            // Downstream did not take main, so the new entry parks in skid.
            skid_d  = in_payload;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end

        ST_FULL: begin
          // in_ready is low in FULL, so only a pop can happen here. The skid
          // entry is younger and moves up to main to keep arrival order.
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end

        default: begin
          // The unused encoding recovers to a safe, empty state.
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written only with non-blocking assignments.
    // Every register then samples its pre-edge value, whatever order the
    // statements run in.
    if (rst) begin
      // NOTE: the payload registers are reset as well, not only the state.
      // This gives a known NOP value after reset, which matters for
      // equivalence and debug. Their width is small enough that this costs
      // little.
      state_q <= ST_EMPTY;
      main_q  <= NOP_PAYLOAD;
      skid_q  <= NOP_PAYLOAD;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_stage_skid_buf.sv
// -----------------------------------------------------------------------------
// tb_stage_skid_buf
//
// Two instances of the design:
//   dut   : default parameters (110-bit payload, stall bit 3, NOP = 0)
//   dut_p : PAYLOAD_W = 8, STALL_IDX = 0, NOP_PAYLOAD = 8'hA5
//
// Inputs are driven on the falling edge. Outputs are checked 2 time units
// later, still inside the low phase. Each expected value describes the outputs
// before the next rising edge, for the pre-edge state and the applied inputs.
// -----------------------------------------------------------------------------
module tb_stage_skid_buf;

  localparam int PW = 110;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [1:0]    occupancy;

  logic          p_rst;
  logic [5:0]    p_stall;
  logic          p_flush;
  logic          p_in_valid;
  logic          p_in_ready;
  logic [7:0]    p_in_payload;
  logic          p_out_valid;
  logic          p_out_ready;
  logic [7:0]    p_out_payload;
  logic [1:0]    p_occupancy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stage_skid_buf dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .occupancy   (occupancy)
  );

  stage_skid_buf #(
    .PAYLOAD_W   (8),
    .STALL_W     (6),
    .STALL_IDX   (0),
    .NOP_PAYLOAD (8'hA5)
  ) dut_p (
    .clk         (clk),
    .rst         (p_rst),
    .stall       (p_stall),
    .flush       (p_flush),
    .in_valid    (p_in_valid),
    .in_ready    (p_in_ready),
    .in_payload  (p_in_payload),
    .out_valid   (p_out_valid),
    .out_ready   (p_out_ready),
    .out_payload (p_out_payload),
    .occupancy   (p_occupancy)
  );

  typedef struct {
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [PW-1:0] din;
    logic          chk;
    logic          e_in_ready;
    logic          e_out_valid;
    logic [PW-1:0] e_dout;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] st, input logic fl, input logic iv,
                     input logic ordy, input logic [PW-1:0] d, input logic c,
                     input logic eir, input logic eov, input logic [PW-1:0] eo,
                     input logic [1:0] eocc);
    vec_t v;
    v.rst = r; v.stall = st; v.flush = fl; v.in_valid = iv; v.out_ready = ordy;
    v.din = d; v.chk = c; v.e_in_ready = eir; v.e_out_valid = eov; v.e_dout = eo;
    v.e_occ = eocc;
    vecs.push_back(v);
  endtask

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] S3 = 6'b001000;
  localparam logic [5:0] SX = 6'b110111; // every bit except bit 3

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_payload = '0;
    p_rst = 1'b1; p_stall = '0; p_flush = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b0;
    p_in_payload = '0;

    //   rst st  fl iv ordy din     chk ir ov dout    occ
    add(1, S0, 0, 0, 0, 'h0,   0, 0, 0, 'h0,   0); // reset edge
    add(0, S0, 0, 0, 0, 'h0,   1, 1, 0, 'h0,   0); // reset state
    // streaming A, B, C
    add(0, S0, 0, 1, 1, 'h111, 1, 1, 0, 'h0,   0);
    add(0, S0, 0, 1, 1, 'h222, 1, 1, 1, 'h111, 1);
    add(0, S0, 0, 1, 1, 'h333, 1, 1, 1, 'h222, 1);
    add(0, S0, 0, 0, 1, 'h0,   1, 1, 1, 'h333, 1);
    add(0, S0, 0, 0, 1, 'h0,   1, 1, 0, 'h0,   0);
    // backpressure: fill to 2, then drain in order
    add(0, S0, 0, 1, 0, 'h444, 1, 1, 0, 'h0,   0);
    add(0, S0, 0, 1, 0, 'h555, 1, 1, 1, 'h444, 1);
    add(0, S0, 0, 1, 1, 'hBAD, 1, 0, 1, 'h444, 2); // FULL: offered entry refused
    add(0, S0, 0, 0, 1, 'h0,   1, 1, 1, 'h555, 1);
    add(0, S0, 0, 0, 1, 'h0,   1, 1, 0, 'h0,   0);
    // stall on bit 3 for 3 cycles while holding one entry
    add(0, S0, 0, 1, 0, 'h666, 1, 1, 0, 'h0,   0);
    add(0, S3, 0, 1, 1, 'h777, 1, 0, 0, 'h666, 1);
    add(0, S3, 0, 1, 1, 'h777, 1, 0, 0, 'h666, 1);
    add(0, S3, 0, 1, 1, 'h777, 1, 0, 0, 'h666, 1);
    add(0, S0, 0, 0, 1, 'h0,   1, 1, 1, 'h666, 1);
    add(0, S0, 0, 0, 1, 'h0,   1, 1, 0, 'h0,   0);
    // other stall bits do not freeze this stage
    add(0, SX, 0, 1, 0, 'h888, 1, 1, 0, 'h0,   0);
    add(0, SX, 0, 0, 1, 'h0,   1, 1, 1, 'h888, 1);
    add(0, S0, 0, 0, 0, 'h0,   1, 1, 0, 'h0,   0);
    // flush from FULL with in_valid high
    add(0, S0, 0, 1, 0, 'h999, 1, 1, 0, 'h0,   0);
    add(0, S0, 0, 1, 0, 'hAAA, 1, 1, 1, 'h999, 1);
    add(0, S0, 1, 1, 1, 'hBBB, 1, 0, 0, 'h999, 2);
    add(0, S0, 0, 0, 0, 'h0,   1, 1, 0, 'h0,   0);
    // flush beats stall
    add(0, S0, 0, 1, 0, 'hCCC, 1, 1, 0, 'h0,   0);
    add(0, S3, 1, 1, 1, 'hDDD, 1, 0, 0, 'hCCC, 1);
    add(0, S0, 0, 0, 0, 'h0,   1, 1, 0, 'h0,   0);
    // reset mid-stream from FULL, with stall set
    add(0, S0, 0, 1, 0, 'hEEE, 1, 1, 0, 'h0,   0);
    add(0, S0, 0, 1, 0, 'hFFF, 1, 1, 1, 'hEEE, 1);
    add(1, S3, 0, 1, 1, 'h123, 1, 0, 0, 'hEEE, 2);
    add(0, S3, 0, 1, 1, 'h456, 1, 0, 0, 'h0,   0);
    add(0, S0, 0, 0, 0, 'h0,   1, 1, 0, 'h0,   0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall; flush = vecs[i].flush;
      in_valid = vecs[i].in_valid; out_ready = vecs[i].out_ready; in_payload = vecs[i].din;
      if (i == 1) p_rst = 1'b0;
      #2;
      if (vecs[i].chk) begin
        check($sformatf("v%0d in_ready", i),    128'(in_ready),    128'(vecs[i].e_in_ready));
        check($sformatf("v%0d out_valid", i),   128'(out_valid),   128'(vecs[i].e_out_valid));
        check($sformatf("v%0d out_payload", i), 128'(out_payload), 128'(vecs[i].e_dout));
        check($sformatf("v%0d occupancy", i),   128'(occupancy),   128'(vecs[i].e_occ));
      end
    end

    // Long stream with out_ready held high: one entry per cycle, no bubbles.
    // The first item also uses a full-width payload to exercise the top bits.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 1'b0; stall = S0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      in_payload = (i == 0) ? {1'b1, 105'd0, 4'hF} : PW'(32'h1000 + i);
      #2;
      check($sformatf("stream%0d in_ready", i), 128'(in_ready), 128'(1'b1));
      if (i == 0) begin
        check("stream0 occupancy", 128'(occupancy), 128'(2'd0));
      end else begin
        check($sformatf("stream%0d out_valid", i), 128'(out_valid), 128'(1'b1));
        check($sformatf("stream%0d occupancy", i), 128'(occupancy), 128'(2'd1));
        check($sformatf("stream%0d out_payload", i), 128'(out_payload),
              (i == 1) ? 128'({1'b1, 105'd0, 4'hF}) : 128'(32'h1000 + i - 1));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    check("stream tail payload", 128'(out_payload), 128'(32'h1007));
    @(negedge clk);
    #2;
    check("stream drained occupancy", 128'(occupancy), 128'(2'd0));

    // Non-default instance: NOP = A5, stall responds only to bit 0.
    @(negedge clk);
    p_stall = 6'b000000; p_in_valid = 1'b0; p_out_ready = 1'b0;
    #2;
    check("p empty payload", 128'(p_out_payload), 128'(8'hA5));
    check("p empty out_valid", 128'(p_out_valid), 128'(1'b0));
    check("p empty in_ready", 128'(p_in_ready), 128'(1'b1));
    @(negedge clk);
    p_stall = 6'b001000; p_in_valid = 1'b1; p_in_payload = 8'h3C;
    #2;
    check("p bit3 ignored in_ready", 128'(p_in_ready), 128'(1'b1));
    @(negedge clk);
    p_in_valid = 1'b0;
    #2;
    check("p held out_valid", 128'(p_out_valid), 128'(1'b1));
    check("p held payload", 128'(p_out_payload), 128'(8'h3C));
    @(negedge clk);
    p_stall = 6'b000001; p_out_ready = 1'b1; p_in_valid = 1'b1; p_in_payload = 8'h77;
    #2;
    check("p bit0 freezes in_ready", 128'(p_in_ready), 128'(1'b0));
    check("p bit0 freezes out_valid", 128'(p_out_valid), 128'(1'b0));
    check("p frozen occupancy", 128'(p_occupancy), 128'(2'd1));
    @(negedge clk);
    p_stall = 6'b000000; p_in_valid = 1'b0;
    #2;
    check("p release payload", 128'(p_out_payload), 128'(8'h3C));
    @(negedge clk);
    #2;
    check("p drained payload", 128'(p_out_payload), 128'(8'hA5));
    check("p drained occupancy", 128'(p_occupancy), 128'(2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
